output_buffer_3x3_ctrl: RTL and testbench



---
 rtl/output_buffer_3x3_ctrl.sv | 159 +++++++++++++++
 tb/tb_output_buffer_3x3_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/output_buffer_3x3_ctrl.sv
// Frame sequencer for the padded 3x3 window buffer: zero-fill, interior fill from
// the channel-interleaved conv stream, then window read-out with valid/ready.
module output_buffer_3x3_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int OUT_CHANNELS   = 3,
  parameter int IN_WIDTH       = 5,
  parameter int IN_HEIGHT      = 5,
  localparam int PAD_WIDTH     = IN_WIDTH + 2,
  localparam int PAD_HEIGHT    = IN_HEIGHT + 2,
  localparam int DEPTH         = PAD_WIDTH * PAD_HEIGHT * OUT_CHANNELS,
  localparam int RD_ADDR_WIDTH = $clog2(IN_WIDTH * IN_HEIGHT),
  localparam int WR_ADDR_WIDTH = $clog2(DEPTH),
  localparam int WIN_WIDTH     = 9 * DATA_WIDTH * OUT_CHANNELS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     done,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     buf_wr_en,
  output logic                     buf_is_padding,
  output logic [WR_ADDR_WIDTH-1:0] buf_wr_addr,
  output logic [DATA_WIDTH-1:0]    buf_wr_data,
  output logic                     buf_rd_en,
  output logic [RD_ADDR_WIDTH-1:0] buf_rd_addr,
  input  logic [WIN_WIDTH-1:0]     buf_rd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIN_WIDTH-1:0]     out_data,
  output logic                     out_last
);

  localparam int N     = IN_WIDTH * IN_HEIGHT;
  localparam int CH_W  = $clog2(OUT_CHANNELS) + 1;
  localparam int COL_W = $clog2(IN_WIDTH) + 1;
  localparam int ROW_W = $clog2(IN_HEIGHT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_PAD, S_FILL, S_READ} state_t;

  state_t                   state;
  logic [WR_ADDR_WIDTH:0]   pad_cnt;
  logic [CH_W-1:0]          ch;
  logic [COL_W-1:0]         col;
  logic [ROW_W-1:0]         row;
  logic [RD_ADDR_WIDTH:0]   issued;
  logic [RD_ADDR_WIDTH-1:0] win_idx;
  logic                     accept;
  logic                     last_sample;
  logic                     last_accept;
  logic [WR_ADDR_WIDTH-1:0] fill_addr;

  assign in_ready    = (state == S_FILL);
  assign accept      = in_ready && in_valid;
  assign last_sample = (ch == CH_W'(OUT_CHANNELS - 1)) && (col == COL_W'(IN_WIDTH - 1)) &&
                       (row == ROW_W'(IN_HEIGHT - 1));
  assign out_data    = buf_rd_data;
  assign out_last    = out_valid && (win_idx == RD_ADDR_WIDTH'(N - 1));
  assign last_accept = out_last && out_ready;
  assign buf_rd_en   = (state == S_READ) && (issued < (RD_ADDR_WIDTH + 1)'(N)) &&
                       (!out_valid || out_ready);
  assign buf_rd_addr = issued[RD_ADDR_WIDTH-1:0];

  // Interior location skips the one-pixel zero border on every side.
  assign fill_addr = WR_ADDR_WIDTH'(((int'(row) + 1) * PAD_WIDTH + int'(col) + 1) * OUT_CHANNELS
                                    + int'(ch));

  always_comb begin
    buf_wr_en      = 1'b0;
    buf_is_padding = 1'b0;
    buf_wr_addr    = '0;
    buf_wr_data    = '0;
    case (state)
      S_PAD: begin
        buf_wr_en      = 1'b1;
        buf_is_padding = 1'b1;
        buf_wr_addr    = pad_cnt[WR_ADDR_WIDTH-1:0];
      end
      S_FILL: begin
        if (accept) begin
          buf_wr_en   = 1'b1;
          buf_wr_addr = fill_addr;
          buf_wr_data = in_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pad_cnt   <= '0;
      ch        <= '0;
      col       <= '0;
      row       <= '0;
      issued    <= '0;
      win_idx   <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_PAD;
            pad_cnt <= '0;
            ch      <= '0;
            col     <= '0;
            row     <= '0;
            issued  <= '0;
            win_idx <= '0;
          end
        end
        S_PAD: begin
          if (pad_cnt == (WR_ADDR_WIDTH + 1)'(DEPTH - 1)) state <= S_FILL;
          else                                              pad_cnt <= pad_cnt + 1'b1;
        end
        S_FILL: begin
          if (accept) begin
            if (last_sample) begin
              state <= S_READ;
            end else if (ch != CH_W'(OUT_CHANNELS - 1)) begin
              ch <= ch + 1'b1;
            end else begin
              ch <= '0;
              if (col != COL_W'(IN_WIDTH - 1)) begin
                col <= col + 1'b1;
              end else begin
                col <= '0;
                row <= row + 1'b1;
              end
            end
          end
        end
        S_READ: begin
          // A fresh read replaces the presented window; otherwise an accept empties the slot.
          if (buf_rd_en) begin
            issued    <= issued + 1'b1;
            win_idx   <= issued[RD_ADDR_WIDTH-1:0];
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
          if (last_accept) begin
            state     <= S_IDLE;
            done      <= 1'b1;
            out_valid <= 1'b0;
            issued    <= '0;
            win_idx   <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_buffer_3x3_ctrl.sv
// Directed bench for output_buffer_3x3_ctrl (5x5x3): pad, fill, read-out, stall and
// mid-frame reset, with a behavioural window buffer providing one-cycle read latency.
module tb_output_buffer_3x3_ctrl;

  localparam int DW   = 8;
  localparam int WINW = 216;

  logic            clk = 1'b0;
  logic            rst_n, start, done;
  logic            in_valid, in_ready;
  logic [DW-1:0]   in_data;
  logic            buf_wr_en, buf_is_padding;
  logic [7:0]      buf_wr_addr;
  logic [DW-1:0]   buf_wr_data;
  logic            buf_rd_en;
  logic [4:0]      buf_rd_addr;
  logic [WINW-1:0] buf_rd_data = '0;
  logic            out_valid, out_ready, out_last;
  logic [WINW-1:0] out_data;

  int tests  = 0;
  int failed = 0;

  output_buffer_3x3_ctrl #(
    .DATA_WIDTH(8), .OUT_CHANNELS(3), .IN_WIDTH(5), .IN_HEIGHT(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .buf_wr_en(buf_wr_en), .buf_is_padding(buf_is_padding),
    .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  function automatic logic [WINW-1:0] win(input int a);
    logic [7:0] b;
    b = 8'(a * 7 + 3);
    return {27{b}};
  endfunction

  // Window buffer: data appears one cycle after a read, held while no read is issued.
  always @(posedge clk) if (buf_rd_en) buf_rd_data <= win(int'(buf_rd_addr));

  function automatic int fill_addr(input int k);
    return (((k / 15) + 1) * 7 + ((k / 3) % 5) + 1) * 3 + (k % 3);
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cyc(); cyc();
    #1;
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", buf_wr_en, 0);
    chk("rst_is_pad", buf_is_padding, 0);
    chk("rst_rd_en", buf_rd_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_wr_addr", buf_wr_addr, 0);
    chk("rst_wr_data", buf_wr_data, 0);
    chk("rst_rd_addr", buf_rd_addr, 0);

    // Frame 1: pad, continuous fill, free-running read-out
    rst_n = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 147; i++) begin
      #1;
      chk("pad_wr_en", buf_wr_en, 1);
      chk("pad_is_pad", buf_is_padding, 1);
      chk("pad_addr", buf_wr_addr, i);
      chk("pad_data", buf_wr_data, 0);
      chk("pad_in_ready", in_ready, 0);
      chk("pad_rd_en", buf_rd_en, 0);
      cyc();
    end
    for (int k = 0; k < 75; k++) begin
      in_valid = 1'b1; in_data = 8'(k);
      #1;
      chk("fill_in_ready", in_ready, 1);
      chk("fill_wr_en", buf_wr_en, 1);
      chk("fill_is_pad", buf_is_padding, 0);
      chk("fill_addr", buf_wr_addr, fill_addr(k));
      chk("fill_data", buf_wr_data, k);
      chk("fill_rd_en", buf_rd_en, 0);
      if (k == 0)  chk("fill_addr_1st", buf_wr_addr, 24);
      if (k == 2)  chk("fill_addr_3rd", buf_wr_addr, 26);
      if (k == 3)  chk("fill_addr_4th", buf_wr_addr, 27);
      if (k == 15) chk("fill_addr_16th", buf_wr_addr, 45);
      if (k == 74) chk("fill_addr_last", buf_wr_addr, 122);
      cyc();
    end
    in_valid = 1'b0;
    for (int j = 0; j <= 25; j++) begin
      #1;
      chk("rd_in_ready", in_ready, 0);
      chk("rd_wr_en", buf_wr_en, 0);
      chk("rd_en", buf_rd_en, (j < 25));
      if (j < 25) chk("rd_addr", buf_rd_addr, j);
      chk("rd_out_valid", out_valid, (j > 0));
      chk("rd_out_last", out_last, (j == 25));
      if (j > 0) chk("rd_out_data", out_data, win(j - 1));
      chk("rd_done_low", done, 0);
      cyc();
    end
    #1;
    chk("done_pulse", done, 1);
    chk("done_out_valid", out_valid, 0);
    cyc();
    #1;
    chk("done_cleared", done, 0);

    // Frame 2: toggling in_valid, then a 3-cycle stall on window 6
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (147) cyc();
    s = 0;
    for (int k = 0; k < 149; k++) begin
      in_valid = (k % 2 == 0);
      in_data  = 8'(s ^ 8'h5A);
      #1;
      chk("tog_wr_en", buf_wr_en, in_valid);
      if (in_valid) begin
        chk("tog_addr", buf_wr_addr, fill_addr(s));
        chk("tog_data", buf_wr_data, 8'(s ^ 8'h5A));
        s++;
      end
      cyc();
    end
    in_valid = 1'b0;
    #1;
    chk("tog_in_ready_off", in_ready, 0);
    for (int j = 0; j < 7; j++) begin
      if (j > 0) #1;
      chk("st_rd_en", buf_rd_en, 1);
      chk("st_rd_addr", buf_rd_addr, j);
      cyc();
    end
    out_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      #1;
      chk("stall_rd_en", buf_rd_en, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, win(6));
      chk("stall_last", out_last, 0);
      cyc();
    end
    out_ready = 1'b1;
    #1;
    chk("resume_rd_en", buf_rd_en, 1);
    chk("resume_rd_addr", buf_rd_addr, 7);
    chk("resume_data", out_data, win(6));
    cyc();
    for (int m = 1; m <= 17; m++) begin
      #1;
      chk("post_rd_addr", buf_rd_addr, 7 + m);
      chk("post_data", out_data, win(6 + m));
      chk("post_last", out_last, 0);
      cyc();
    end
    #1;
    chk("st_final_rd_en", buf_rd_en, 0);
    chk("st_final_last", out_last, 1);
    chk("st_final_data", out_data, win(24));
    cyc();
    #1;
    chk("st_done", done, 1);
    cyc();

    // Frame 3: reset after 10 fill samples, then a fresh start re-pads everything
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (147) cyc();
    in_valid = 1'b1;
    repeat (10) cyc();
    in_valid = 1'b0;
    rst_n = 1'b0;
    cyc();
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_wr_en", buf_wr_en, 0);
    chk("mid_rst_wr_addr", buf_wr_addr, 0);
    chk("mid_rst_rd_en", buf_rd_en, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_done", done, 0);
    rst_n = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 147; i++) begin
      #1;
      chk("repad_wr_en", buf_wr_en, 1);
      chk("repad_is_pad", buf_is_padding, 1);
      chk("repad_addr", buf_wr_addr, i);
      cyc();
    end
    #1;
    chk("repad_fill_ready", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
